// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer and the RV32I Controller.
// Holds the state encodings, opcode constants, trap cause codes and the opcode classifier.
package mc_sequencer_pkg;

    // Sequencer state encodings. Values 5 and 6 are never entered on purpose.
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd7;

    // RV32I major opcodes (inst[6:0]).
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Trap cause codes reported on trap_cause.
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ENV     = 2'b01;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b10;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b11;

    // Instruction classes that determine the state walk.
    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_UPPER,
        CLS_JUMP,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_SYSTEM,
        CLS_FENCE,
        CLS_ILLEGAL
    } op_class_t;

    // Map a major opcode onto its sequencing class; anything unknown is illegal.
    function automatic op_class_t classify(input logic [6:0] op);
        case (op)
            OP_ALU_R, OP_ALU_I: return CLS_ALU;
            OP_LUI, OP_AUIPC:   return CLS_UPPER;
            OP_JAL, OP_JALR:    return CLS_JUMP;
            OP_BRANCH:          return CLS_BRANCH;
            OP_LOAD:            return CLS_LOAD;
            OP_STORE:           return CLS_STORE;
            OP_SYSTEM:          return CLS_SYSTEM;
            OP_FENCE:           return CLS_FENCE;
            default:            return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer_mem_wait_timer.sv
// Wait-state counter shared by the instruction and data memory handshakes.
// Counts cycles spent with a request outstanding and no ready, and flags the
// cycle in which one more unanswered cycle would reach the timeout limit.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic ready,
    input  logic clr,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] count_reg;

    // Count unanswered request cycles; any ready, idle or state change restarts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr || !req || ready) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // This cycle is the TIMEOUT_CYCLES-th unanswered one; a limit of 0 never fires.
    assign expired = (TIMEOUT_CYCLES != 0) && req && !ready && (count_reg == LAST);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the RV32I core: walks the datapath through
// FETCH/DECODE/EXEC/MEM/WB, drives register-write enables and memory requests,
// traps into an absorbing HALT state and counts retired instructions.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_we,
    output logic                 opr_we,
    output logic                 alu_we,
    output logic                 pc_we,
    output logic                 rf_we_en,
    output logic                 retire,
    output logic                 halted,
    output logic [1:0]           trap_cause,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    logic [2:0]           state_reg, state_next;
    logic [1:0]           trap_reg, trap_next;
    logic [INSTRET_W-1:0] instret_reg;

    logic imem_req_next, ir_we_next;
    logic timer_req, timer_ready, timer_clr, timer_expired;

    op_class_t op_class;
    logic      is_env, is_nop;

    assign op_class = classify(opcode);
    assign is_env   = (op_class == CLS_SYSTEM) && (funct3 == 3'b000);
    assign is_nop   = (op_class == CLS_FENCE) || ((op_class == CLS_SYSTEM) && (funct3 != 3'b000));

    // The single timer watches whichever memory is currently being requested.
    assign timer_req   = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
    assign timer_ready = (state_reg == ST_FETCH) ? imem_ready : dmem_ready;
    assign timer_clr   = (state_next != state_reg);

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .req    (timer_req),
        .ready  (timer_ready),
        .clr    (timer_clr),
        .expired(timer_expired)
    );

    // Next-state decode plus per-state strobes; strobes are Moore except the ready-qualified ones.
    always_comb begin
        state_next    = state_reg;
        trap_next     = trap_reg;
        imem_req_next = 1'b0;
        ir_we_next    = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        opr_we        = 1'b0;
        alu_we        = 1'b0;
        pc_we         = 1'b0;
        rf_we_en      = 1'b0;
        retire        = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                imem_req_next = 1'b1;
                if (imem_ready) begin
                    ir_we_next = 1'b1;
                    state_next = ST_DECODE;
                end else if (timer_expired) begin
                    state_next = ST_HALT;
                    trap_next  = TRAP_TIMEOUT;
                end
            end
            ST_DECODE: begin
                opr_we = 1'b1;
                if (op_class == CLS_ILLEGAL) begin
                    state_next = ST_HALT;
                    trap_next  = TRAP_ILLEGAL;
                end else if (is_env) begin
                    state_next = ST_HALT;
                    trap_next  = TRAP_ENV;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_we = 1'b1;
                if ((op_class == CLS_BRANCH) || is_nop) begin
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else if ((op_class == CLS_LOAD) || (op_class == CLS_STORE)) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_class == CLS_STORE);
                if (dmem_ready) begin
                    if (op_class == CLS_STORE) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (timer_expired) begin
                    state_next = ST_HALT;
                    trap_next  = TRAP_TIMEOUT;
                end
            end
            ST_WB: begin
                rf_we_en   = 1'b1;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_HALT;
                trap_next  = TRAP_ILLEGAL;
            end
        endcase
    end

    // The reset state is FETCH, so the fetch strobes are held off while reset is asserted.
    assign imem_req = imem_req_next && reset;
    assign ir_we    = ir_we_next && reset;

    // State, trap cause and retired-instruction counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_FETCH;
            trap_reg    <= TRAP_NONE;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            trap_reg  <= trap_next;
            if (retire) begin
                instret_reg <= instret_reg + 1'b1;
            end
        end
    end

    assign halted     = (state_reg == ST_HALT);
    assign trap_cause = trap_reg;
    assign state      = state_reg;
    assign instret    = instret_reg;

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle control sequencer for the RV32I core. It steps the shared IF/ID/EX/MEM_WB datapath through FETCH/DECODE/EXEC/MEM/WB states instead of completing everything in one cycle. It issues per-state register-write enables, and handshakes with instruction and data memories that may insert wait states. It sits beside the combinational Controller, which still supplies sext/alu/npc/wsel selects; this block supplies only timing enables, memory requests, retire/halt status and an instret counter.

Parameters:
TIMEOUT_CYCLES, 255, maximum wait cycles for a memory ready before trapping; 0 disables the timeout
INSTRET_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  7  inst[6:0] from the latched instruction register
funct3  input  3  inst[14:12]; used only to separate ECALL/EBREAK from CSR space
imem_ready  input  1  instruction memory data valid / accept
dmem_ready  input  1  data memory access complete
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write qualifier; valid only while dmem_req=1
ir_we  output  1  latch fetched instruction and pc/pc4
opr_we  output  1  latch rD1, rD2 and ext
alu_we  output  1  latch alu_c and npc
pc_we  output  1  load npc into the PC
rf_we_en  output  1  gate ANDed with Controller rf_we
retire  output  1  one-cycle pulse per completed instruction
halted  output  1  sticky halt indicator
trap_cause  output  2  00 none, 01 ECALL/EBREAK, 10 illegal opcode, 11 memory timeout
state  output  3  current state encoding, for debug
instret  output  INSTRET_W  retired instruction count

Behaviour:
- Reset (reset=0, async): state=FETCH. All strobes 0, halted=0, trap_cause=00, instret=0, wait counter=0. The first imem_req asserts in the first cycle after reset deasserts.
- Opcode classes: ALU (0110011, 0010011), UPPER (0110111, 0010111), JUMP (1101111, 1100111), BRANCH (1100011), LOAD (0000011), STORE (0100011), SYSTEM (1110011), FENCE (0001111). Any other opcode is ILLEGAL.
- FETCH:
  - imem_req=1, held until imem_ready is sampled 1.
  - On the ready cycle, ir_we=1 and the state goes to DECODE.
- DECODE:
  - opr_we=1 for one cycle.
  - Go to EXEC, except: ILLEGAL goes to HALT with cause 10; SYSTEM with funct3=000 goes to HALT with cause 01.
  - SYSTEM with funct3!=000 (CSR) and FENCE are treated as NOPs.
- EXEC:
  - alu_we=1.
  - BRANCH, FENCE, CSR-NOP: pc_we=1, retire=1, then FETCH.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE only. Both are held stable until dmem_ready=1.
  - LOAD on ready: go to WB.
  - STORE on ready: pc_we=1, retire=1, then FETCH.
- WB:
  - rf_we_en=1, pc_we=1, retire=1, then FETCH.
  - JUMP loads npc here; rd gets pc4 via wsel.
- HALT:
  - Absorbing state; all strobes 0, halted=1.
  - trap_cause is held. Only reset exits.
  - The trapping instruction is not retired and does not increment instret.
- Timeout:
  - The wait counter increments each cycle a req is high and ready is low. It clears on ready or on a state change.
  - If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES with ready still low: next state is HALT, cause 11, and req drops the same edge.
- Latency: ALU/UPPER/JUMP take 4 cycles, BRANCH 3, LOAD 5, STORE 4. These assume zero-wait memories; add wait cycles to FETCH/MEM.
- instret increments by 1 on every retire and wraps modulo 2^INSTRET_W.
- ready sampled high outside a req cycle is ignored.
- Reset asserted mid-MEM aborts immediately: dmem_req drops asynchronously and no write strobe completes.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Encodings 5 and 6 are unreachable and recover to HALT with cause 10.

Decomposition:
- Shared package holds:
  - state encodings
  - opcode constants (OP_ALU_R, OP_ALU_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_SYSTEM, OP_FENCE), also used by the Controller
  - trap_cause codes
- One sub-module, mem_wait_timer: the wait counter plus timeout compare, instanced once and selected by the active req.
- The FSM and instret counter stay in mc_sequencer.

Test Plan:
- ADDI x1,x0,5 with zero-wait memories -> states 0,1,2,4,0; exactly one rf_we_en and one pc_we pulse; retire in cycle 4; instret=1.
- LW with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0; WB follows; total 8 cycles; instret=1.
- SW, then BEQ, zero-wait -> SW gives dmem_we=1 for one cycle, no rf_we_en, 4 cycles; BEQ takes 3 cycles with pc_we in EXEC; instret=2.
- Opcode 0000000 fetched -> HALT from the cycle after DECODE; halted=1, trap_cause=10; instret unchanged; imem_req stays 0 for 20 cycles.
- TIMEOUT_CYCLES=4 and imem_ready held 0 -> imem_req high 4 cycles, then HALT with trap_cause=11; deasserting reset mid-run (low, then high) restores FETCH with instret=0.
- ECALL (0x00000073) after 3 ADDIs -> halted=1, trap_cause=01, instret=3.
